tone_divider_scheduler: RTL and testbench
=========================================

Name: tone_divider_scheduler

Overview:
- Arbitrates 8 synth key inputs and drives one programmable clock divider that produces the square-wave note tone.
- Last-pressed-key-wins scheduling. Each selected key maps to a half-period count taken from a fixed note table.
- Note changes take effect only at a half-period boundary, so the tone never glitches.
- Sits between the keypad debouncers and the audio output / PWM stage.

Parameters:
- N_KEYS, 8, number of key requesters. Fixed at 8 for the table below.
- CNT_W, 18, width of the half-period counter.
- DIV_SHIFT, 0, right-shift applied to table values. Simulation uses 14; 0 gives real pitches at 100 MHz.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- key  in  8  level key requests, already debounced and synchronous to clk; bit i = note i
- tone  out  1  square-wave audio output
- active  out  1  high while state is PLAY or RELEASE
- note_idx  out  3  index of the note currently sounding
- toggle  out  1  one-cycle pulse on every tone edge

Behaviour:
- Reset (async, rst=1): state=IDLE; tone=0, active=0, note_idx=0, toggle=0; cnt=0, key_q=0, half=0; pend_vld=0.
- Note table, half-period in clk cycles, indices 0..7 = C4..C5: 191110, 170266, 151685, 143172, 127551, 113636, 101239, 95557.
- half_of(i) = table[i] >> DIV_SHIFT, clamped to a minimum of 1.
- Rising-edge detect: rise = key & ~key_q; key_q <= key every cycle.
- Selection target, evaluated each cycle:
  - if rise != 0: highest-index set bit of rise;
  - else if the key at note_idx (or pend_idx when pend_vld) is released and key != 0: highest-index held key;
  - else: no change.
  - Rise always beats fallback.
- IDLE:
  - tone=0, cnt=0.
  - If key != 0 at edge E: state<=PLAY, active<=1, note_idx<=target, half<=half_of(target), cnt<=0.
  - First tone rising edge at E+half(target) (toggle pulse in that same cycle).
- PLAY:
  - Wrap: if cnt==half-1 then cnt<=0, tone<=~tone, toggle<=1; else cnt<=cnt+1.
  - If target differs from the sounding note: pend_idx<=target, pend_vld<=1.
  - If target equals the sounding note: pend_vld<=0; no change occurs.
  - At a wrap with pend_vld: note_idx<=pend_idx, half<=half_of(pend_idx), pend_vld<=0. The new period starts with the next half-period.
  - If key==0 and tone==0: state<=IDLE, active<=0, cnt<=0, pend_vld<=0.
  - If key==0 and tone==1: state<=RELEASE.
- RELEASE:
  - Counting continues unchanged.
  - At the wrap (tone 1->0): state<=IDLE, active<=0, cnt<=0.
  - If a key rises during RELEASE: state<=PLAY, with the target pending. It is applied at the wrap; tone goes low there and continues at the new pitch.
- toggle: high exactly one cycle per tone transition; 0 otherwise.
- Widths:
  - cnt and half are CNT_W bits.
  - Table constants fit in 18 bits; DIV_SHIFT never overflows.
  - cnt never exceeds half-1.
- Reset mid-tone: tone drops to 0 asynchronously. No pending state survives reset.

Test Plan:
- DIV_SHIFT=14 (halves: 11, 10, 9, 8, 7, 6, 6, 5). Reset, then key=8'h01 held -> active=1 one cycle later. tone rises 11 cycles after selection edge, then toggles every 11 cycles. note_idx=0. toggle pulses are 1 cycle wide.
- Key 0 playing, then key=8'h81 (key 7 pressed) mid half-period -> note_idx stays 0 until the next wrap, then becomes 7. Half-periods after that are 5 cycles. No half-period has a length other than 11 or 5.
- key=8'h81 held, then release key 7 (key=8'h01) -> falls back to note 0 at the next wrap (half=11).
- key 8'h00 released while tone=1 -> RELEASE; tone falls at the end of the current half-period; active=0 the cycle after. Release while tone=0 -> IDLE next cycle, tone stays 0.
- Simultaneous rise of keys 2 and 5 from IDLE (key=8'h24) -> note_idx=5, half=6. Press key 3 while 5 is held -> note_idx=3 at the next wrap.
- Assert rst mid-high half-period -> tone=0, active=0, toggle=0 immediately. After deassert with key held -> restarts from IDLE with full first half-period.

Source files
------------

// File: rtl/tone_divider_scheduler.sv
// rtl/tone_divider_scheduler.sv - last-key-wins note scheduler driving a glitch-free half-period tone divider
module tone_divider_scheduler #(
  parameter int N_KEYS    = 8,
  parameter int CNT_W     = 18,
  parameter int DIV_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic              tone,
  output logic              active,
  output logic [2:0]        note_idx,
  output logic              toggle
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  half;
  logic [N_KEYS-1:0] key_q;
  logic [2:0]        pend_idx;
  logic              pend_vld;

  logic [N_KEYS-1:0] rise;
  logic [2:0]        cur_idx;
  logic [2:0]        tgt_idx;
  logic [2:0]        idle_idx;
  logic [2:0]        next_note;
  logic              tgt_vld;
  logic              wrap;

  function automatic logic [2:0] msb_idx(input logic [N_KEYS-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // C4..C5 half-periods at 100 MHz, scaled down for simulation via DIV_SHIFT
  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] i);
    logic [17:0] v;
    case (i)
      3'd0:    v = 18'd191110;
      3'd1:    v = 18'd170266;
      3'd2:    v = 18'd151685;
      3'd3:    v = 18'd143172;
      3'd4:    v = 18'd127551;
      3'd5:    v = 18'd113636;
      3'd6:    v = 18'd101239;
      default: v = 18'd95557;
    endcase
    v = v >> DIV_SHIFT;
    if (v == 18'd0) v = 18'd1;
    return CNT_W'(v);
  endfunction

  always_comb begin
    rise      = key & ~key_q;
    cur_idx   = pend_vld ? pend_idx : note_idx;
    tgt_vld   = 1'b0;
    tgt_idx   = note_idx;
    if (rise != '0) begin
      tgt_vld = 1'b1;
      tgt_idx = msb_idx(rise);
    end else if (!key[cur_idx] && key != '0) begin
      tgt_vld = 1'b1;
      tgt_idx = msb_idx(key);
    end
    idle_idx  = (rise != '0) ? msb_idx(rise) : msb_idx(key);
    wrap      = (cnt == half - ONE);
    // Pending decisions compare against the note that will sound after this edge
    next_note = (wrap && pend_vld) ? pend_idx : note_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tone     <= 1'b0;
      active   <= 1'b0;
      note_idx <= 3'd0;
      toggle   <= 1'b0;
      cnt      <= '0;
      half     <= '0;
      key_q    <= '0;
      pend_idx <= 3'd0;
      pend_vld <= 1'b0;
    end else begin
      key_q  <= key;
      toggle <= 1'b0;
      case (state)
        S_PLAY, S_RELEASE: begin
          if (state == S_RELEASE && rise == '0) begin
            if (wrap) begin
              state    <= S_IDLE;
              active   <= 1'b0;
              tone     <= 1'b0;
              toggle   <= 1'b1;
              cnt      <= '0;
              pend_vld <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end else if (key == '0 && !tone) begin
            state    <= S_IDLE;
            active   <= 1'b0;
            cnt      <= '0;
            pend_vld <= 1'b0;
          end else if (key == '0 && wrap) begin
            // Released exactly on the falling wrap: finish the cycle right here
            state    <= S_IDLE;
            active   <= 1'b0;
            tone     <= 1'b0;
            toggle   <= 1'b1;
            cnt      <= '0;
            pend_vld <= 1'b0;
          end else begin
            state <= (key == '0) ? S_RELEASE : S_PLAY;
            if (wrap) begin
              cnt    <= '0;
              tone   <= ~tone;
              toggle <= 1'b1;
              if (pend_vld) begin
                note_idx <= pend_idx;
                half     <= half_of(pend_idx);
                pend_vld <= 1'b0;
              end
            end else begin
              cnt <= cnt + ONE;
            end
            if (tgt_vld) begin
              if (tgt_idx != next_note) begin
                pend_idx <= tgt_idx;
                pend_vld <= 1'b1;
              end else begin
                pend_vld <= 1'b0;
              end
            end
          end
        end
        default: begin
          tone     <= 1'b0;
          cnt      <= '0;
          pend_vld <= 1'b0;
          if (key != '0) begin
            state    <= S_PLAY;
            active   <= 1'b1;
            note_idx <= idle_idx;
            half     <= half_of(idle_idx);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_divider_scheduler.sv
// tb/tb_tone_divider_scheduler.sv - directed scoreboard bench for tone_divider_scheduler
module tb_tone_divider_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic       tone;
  logic       active;
  logic [2:0] note_idx;
  logic       toggle;

  int cyc       = 0;
  int last_edge = 0;
  int checks    = 0;
  int errors    = 0;

  typedef struct {
    logic       tone;
    logic [2:0] note;
    int         gap;
  } edge_t;

  edge_t sb[$];

  tone_divider_scheduler #(
    .N_KEYS   (8),
    .CNT_W    (18),
    .DIV_SHIFT(14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .tone    (tone),
    .active  (active),
    .note_idx(note_idx),
    .toggle  (toggle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic t, input logic [2:0] n, input int g);
    edge_t e;
    e.tone = t;
    e.note = n;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic mark();
    last_edge = cyc;
  endtask

  // Waits (bounded) for the next toggle pulse and compares it with the scoreboard head
  task automatic wait_edge();
    edge_t e;
    int    n;
    check("sb_nonempty", 32'(sb.size() > 0), 32'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (toggle !== 1'b1 && n < 40);
    check("edge_seen", 32'(toggle), 32'(1));
    check("edge_tone", 32'(tone), 32'(e.tone));
    check("edge_note", 32'(note_idx), 32'(e.note));
    check("edge_gap", 32'(cyc - last_edge), 32'(e.gap));
    last_edge = cyc;
  endtask

  initial begin
    rst = 1'b1;
    key = 8'h00;
    tick(3);
    check("rst_tone", 32'(tone), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_note", 32'(note_idx), 32'(0));
    check("rst_toggle", 32'(toggle), 32'(0));

    // Key 0 from idle: half = 11
    rst = 1'b0;
    key = 8'h01;
    tick(1);
    check("start_active", 32'(active), 32'(1));
    check("start_tone", 32'(tone), 32'(0));
    check("start_note", 32'(note_idx), 32'(0));
    mark();
    push(1'b1, 3'd0, 11);
    push(1'b0, 3'd0, 11);
    push(1'b1, 3'd0, 11);
    wait_edge();
    tick(1);
    check("pulse_width", 32'(toggle), 32'(0));
    check("tone_held", 32'(tone), 32'(1));
    wait_edge();
    wait_edge();

    // Key 7 pressed mid half-period: change waits for the wrap
    tick(3);
    key = 8'h81;
    tick(2);
    check("pend_note_hold", 32'(note_idx), 32'(0));
    push(1'b0, 3'd7, 11);
    push(1'b1, 3'd7, 5);
    push(1'b0, 3'd7, 5);
    wait_edge();
    wait_edge();
    wait_edge();

    // Release key 7: fall back to held key 0
    key = 8'h01;
    push(1'b1, 3'd0, 5);
    push(1'b0, 3'd0, 11);
    push(1'b1, 3'd0, 11);
    wait_edge();
    wait_edge();
    wait_edge();

    // Release everything while tone is high
    tick(2);
    key = 8'h00;
    tick(1);
    check("release_active", 32'(active), 32'(1));
    push(1'b0, 3'd0, 11);
    wait_edge();
    check("release_done_active", 32'(active), 32'(0));
    tick(1);
    check("idle_toggle", 32'(toggle), 32'(0));
    check("idle_tone", 32'(tone), 32'(0));

    // Release while tone is low: straight back to idle
    key = 8'h01;
    tick(1);
    check("short_active", 32'(active), 32'(1));
    key = 8'h00;
    tick(1);
    check("short_idle_active", 32'(active), 32'(0));
    check("short_idle_tone", 32'(tone), 32'(0));
    tick(15);
    check("short_quiet_tone", 32'(tone), 32'(0));
    check("short_quiet_active", 32'(active), 32'(0));

    // Simultaneous keys 2 and 5: highest wins
    key = 8'h24;
    tick(1);
    check("dual_note", 32'(note_idx), 32'(5));
    check("dual_active", 32'(active), 32'(1));
    mark();
    push(1'b1, 3'd5, 6);
    push(1'b0, 3'd5, 6);
    wait_edge();
    wait_edge();
    tick(1);
    key = 8'h2C;
    push(1'b1, 3'd3, 6);
    push(1'b0, 3'd3, 8);
    push(1'b1, 3'd3, 8);
    wait_edge();
    wait_edge();
    wait_edge();

    // Asynchronous reset during the high half-period
    tick(3);
    rst = 1'b1;
    #1;
    check("arst_tone", 32'(tone), 32'(0));
    check("arst_active", 32'(active), 32'(0));
    check("arst_toggle", 32'(toggle), 32'(0));
    check("arst_note", 32'(note_idx), 32'(0));
    tick(2);
    rst = 1'b0;
    tick(1);
    check("restart_active", 32'(active), 32'(1));
    check("restart_note", 32'(note_idx), 32'(5));
    check("restart_tone", 32'(tone), 32'(0));
    mark();
    push(1'b1, 3'd5, 6);
    wait_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
